// File: rtl/decode_stage_if.sv
// Handshake bundle for the decode stage: fetch-side instruction input and the
// decoded-record output toward execute.
interface decode_stage_if #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_insn;
    logic [PC_WIDTH-1:0]   in_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [PC_WIDTH-1:0]   out_pc;
    logic [4:0]            out_rs;
    logic [4:0]            out_rt;
    logic [4:0]            out_dst;
    logic [DATA_WIDTH-1:0] out_imm;
    logic [3:0]            out_alu_code;
    logic [1:0]            out_br_code;
    logic [5:0]            out_flags;
    logic                  out_illegal;
    logic [31:0]           stall_count;

    modport master (
        output flush, in_valid, in_insn, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs, out_rt, out_dst, out_imm,
               out_alu_code, out_br_code, out_flags, out_illegal, stall_count
    );

    modport slave (
        input  flush, in_valid, in_insn, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs, out_rt, out_dst, out_imm,
               out_alu_code, out_br_code, out_flags, out_illegal, stall_count
    );
endinterface

// File: rtl/decode_stage.sv
// MIPS-subset decode stage: decodes one instruction per accept into a small
// record FIFO, with a load-use interlock that holds back dependent instructions.
module decode_stage #(
    parameter int unsigned PC_WIDTH       = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEPTH          = 2,
    parameter int unsigned LOAD_USE_STALL = 1
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);
    localparam logic [5:0] OpAlu  = 6'h00;
    localparam logic [5:0] OpLd   = 6'h23;
    localparam logic [5:0] OpSt   = 6'h2B;
    localparam logic [5:0] OpAddi = 6'h08;
    localparam logic [5:0] OpAndi = 6'h0C;
    localparam logic [5:0] OpOri  = 6'h0D;
    localparam logic [5:0] OpBeq  = 6'h04;
    localparam logic [5:0] OpBne  = 6'h05;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;
    localparam logic [5:0] FnSll = 6'h00;
    localparam logic [5:0] FnSrl = 6'h02;

    localparam logic [3:0] ALU_CODE_ADD = 4'd0;
    localparam logic [3:0] ALU_CODE_SUB = 4'd1;
    localparam logic [3:0] ALU_CODE_AND = 4'd2;
    localparam logic [3:0] ALU_CODE_OR  = 4'd3;
    localparam logic [3:0] ALU_CODE_SLT = 4'd4;
    localparam logic [3:0] ALU_CODE_SLL = 4'd5;
    localparam logic [3:0] ALU_CODE_SRL = 4'd6;

    localparam logic [1:0] BR_CODE_UNTAKEN = 2'd0;
    localparam logic [1:0] BR_CODE_EQ      = 2'd1;
    localparam logic [1:0] BR_CODE_NE      = 2'd2;

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned LdW  = (LOAD_USE_STALL > 0) ? $clog2(LOAD_USE_STALL + 1) : 1;

    // flags = {isLoad, isStore, isSrcA_Rt, rfWrEnable, isALUInConstant, pcWrEnable}
    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [4:0]            rs;
        logic [4:0]            rt;
        logic [4:0]            dst;
        logic [DATA_WIDTH-1:0] imm;
        logic [3:0]            alu;
        logic [1:0]            br;
        logic [5:0]            flags;
        logic                  illegal;
    } rec_t;

    function automatic logic [PtrW-1:0] next_ptr(logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    rec_t                  rec;
    logic                  rd_rs, rd_rt;
    logic [DATA_WIDTH-1:0] imm_sext, imm_zext;
    logic [5:0]            op, funct;

    always_comb begin
        op       = bus.in_insn[31:26];
        funct    = bus.in_insn[5:0];
        imm_sext = DATA_WIDTH'($signed(bus.in_insn[15:0]));
        imm_zext = DATA_WIDTH'(bus.in_insn[15:0]);
        rec      = '0;
        rec.pc   = bus.in_pc;
        rec.rs   = bus.in_insn[25:21];
        rec.rt   = bus.in_insn[20:16];
        rec.alu  = ALU_CODE_ADD;
        rec.br   = BR_CODE_UNTAKEN;
        rd_rs    = 1'b0;
        rd_rt    = 1'b0;
        unique case (op)
            OpAlu: begin
                rec.dst   = bus.in_insn[15:11];
                rec.flags = 6'b000100;
                rd_rs     = 1'b1;
                rd_rt     = 1'b1;
                unique case (funct)
                    FnAdd: rec.alu = ALU_CODE_ADD;
                    FnSub: rec.alu = ALU_CODE_SUB;
                    FnAnd: rec.alu = ALU_CODE_AND;
                    FnOr:  rec.alu = ALU_CODE_OR;
                    FnSlt: rec.alu = ALU_CODE_SLT;
                    FnSll, FnSrl: begin
                        // Shifts take rt as operand A and shamt as the constant.
                        rec.alu   = (funct == FnSll) ? ALU_CODE_SLL : ALU_CODE_SRL;
                        rec.flags = 6'b001110;
                        rec.imm   = DATA_WIDTH'(bus.in_insn[10:6]);
                        rd_rs     = 1'b0;
                    end
                    default: begin
                        rec.dst     = '0;
                        rec.flags   = '0;
                        rec.illegal = 1'b1;
                        rd_rs       = 1'b0;
                        rd_rt       = 1'b0;
                    end
                endcase
            end
            OpLd: begin
                rec.dst   = rec.rt;
                rec.flags = 6'b100110;
                rec.imm   = imm_sext;
                rd_rs     = 1'b1;
            end
            OpSt: begin
                rec.flags = 6'b010010;
                rec.imm   = imm_sext;
                rd_rs     = 1'b1;
                rd_rt     = 1'b1;
            end
            OpAddi, OpAndi, OpOri: begin
                rec.dst   = rec.rt;
                rec.flags = 6'b000110;
                rec.imm   = (op == OpAddi) ? imm_sext : imm_zext;
                rec.alu   = (op == OpAddi) ? ALU_CODE_ADD :
                            (op == OpAndi) ? ALU_CODE_AND : ALU_CODE_OR;
                rd_rs     = 1'b1;
            end
            OpBeq, OpBne: begin
                rec.flags = 6'b000001;
                rec.imm   = imm_sext;
                rec.alu   = ALU_CODE_SUB;
                rec.br    = (op == OpBeq) ? BR_CODE_EQ : BR_CODE_NE;
                rd_rs     = 1'b1;
                rd_rt     = 1'b1;
            end
            default: rec.illegal = 1'b1;
        endcase
    end

    rec_t            mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [LdW-1:0]  ld_cnt_q, ld_cnt_d;
    logic [4:0]      ld_dst_q, ld_dst_d;
    logic [31:0]     stall_q, stall_d;
    logic            full, interlock, push, pop;
    rec_t            head;

    assign full      = (count_q == CntW'(DEPTH));
    assign interlock = (ld_cnt_q != '0) && bus.in_valid &&
                       ((rd_rs && (rec.rs == ld_dst_q)) || (rd_rt && (rec.rt == ld_dst_q)));
    assign bus.in_ready  = !full && !bus.flush && !interlock;
    assign bus.out_valid = (count_q != '0);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ld_cnt_d = ld_cnt_q;
        ld_dst_d = ld_dst_q;
        stall_d  = (interlock && (stall_q != '1)) ? stall_q + 32'd1 : stall_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ld_cnt_d = '0;
        end else begin
            if (push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CntW'(1);
            end
            // A newer load restarts the window even if an older one is still counting.
            if (push && rec.flags[5] && (rec.rt != 5'd0)) begin
                ld_cnt_d = LdW'(LOAD_USE_STALL);
                ld_dst_d = rec.rt;
            end else if (ld_cnt_q != '0) begin
                ld_cnt_d = ld_cnt_q - LdW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ld_cnt_q <= '0;
            ld_dst_q <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ld_cnt_q <= ld_cnt_d;
            ld_dst_q <= ld_dst_d;
            stall_q  <= stall_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rec;
    end

    assign head             = mem_q[rd_ptr_q];
    assign bus.out_pc       = head.pc;
    assign bus.out_rs       = head.rs;
    assign bus.out_rt       = head.rt;
    assign bus.out_dst      = head.dst;
    assign bus.out_imm      = head.imm;
    assign bus.out_alu_code = head.alu;
    assign bus.out_br_code  = head.br;
    assign bus.out_flags    = bus.out_valid ? head.flags : 6'b0;
    assign bus.out_illegal  = bus.out_valid && head.illegal;
    assign bus.stall_count  = stall_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then random traffic, all checked
// against a queue-based reference model of the decode rules and handshake.
module tb_decode_stage;
    localparam int unsigned PW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned LUS   = 1;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3;
    localparam logic [3:0] A_SLT = 4'd4, A_SLL = 4'd5, A_SRL = 4'd6;
    localparam logic [1:0] B_UNT = 2'd0, B_EQ = 2'd1, B_NE = 2'd2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if #(.PC_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

    decode_stage #(
        .PC_WIDTH      (PW),
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .LOAD_USE_STALL(LUS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef enum int {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_SLL, K_SRL, K_LD, K_ST,
                      K_ADDI, K_ANDI, K_ORI, K_BEQ, K_BNE, K_ILL} kind_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [1:0]  br;
        logic [5:0]  flags;
        logic        illegal;
    } exp_t;

    exp_t        exp_q[$];
    int          m_ld_cnt = 0;
    logic [4:0]  m_ld_dst = '0;
    logic [31:0] m_stall  = '0;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic kind_e classify(logic [31:0] w);
        case (w[31:26])
            6'h00: case (w[5:0])
                6'h20: return K_ADD;
                6'h22: return K_SUB;
                6'h24: return K_AND;
                6'h25: return K_OR;
                6'h2A: return K_SLT;
                6'h00: return K_SLL;
                6'h02: return K_SRL;
                default: return K_ILL;
            endcase
            6'h23: return K_LD;
            6'h2B: return K_ST;
            6'h08: return K_ADDI;
            6'h0C: return K_ANDI;
            6'h0D: return K_ORI;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            default: return K_ILL;
        endcase
    endfunction

    function automatic exp_t model(logic [31:0] w, logic [31:0] pc);
        exp_t        e;
        kind_e       k;
        logic [31:0] sx, zx;
        k  = classify(w);
        sx = {{16{w[15]}}, w[15:0]};
        zx = {16'h0, w[15:0]};
        e = '0;
        e.pc = pc;
        e.rs = w[25:21];
        e.rt = w[20:16];
        case (k)
            K_ADD:  begin e.alu = A_ADD; e.dst = w[15:11]; e.flags = 6'b000100; end
            K_SUB:  begin e.alu = A_SUB; e.dst = w[15:11]; e.flags = 6'b000100; end
            K_AND:  begin e.alu = A_AND; e.dst = w[15:11]; e.flags = 6'b000100; end
            K_OR:   begin e.alu = A_OR;  e.dst = w[15:11]; e.flags = 6'b000100; end
            K_SLT:  begin e.alu = A_SLT; e.dst = w[15:11]; e.flags = 6'b000100; end
            K_SLL:  begin e.alu = A_SLL; e.dst = w[15:11]; e.flags = 6'b001110;
                          e.imm = {27'h0, w[10:6]}; end
            K_SRL:  begin e.alu = A_SRL; e.dst = w[15:11]; e.flags = 6'b001110;
                          e.imm = {27'h0, w[10:6]}; end
            K_LD:   begin e.alu = A_ADD; e.dst = w[20:16]; e.flags = 6'b100110; e.imm = sx; end
            K_ST:   begin e.alu = A_ADD; e.flags = 6'b010010; e.imm = sx; end
            K_ADDI: begin e.alu = A_ADD; e.dst = w[20:16]; e.flags = 6'b000110; e.imm = sx; end
            K_ANDI: begin e.alu = A_AND; e.dst = w[20:16]; e.flags = 6'b000110; e.imm = zx; end
            K_ORI:  begin e.alu = A_OR;  e.dst = w[20:16]; e.flags = 6'b000110; e.imm = zx; end
            K_BEQ:  begin e.alu = A_SUB; e.br = B_EQ; e.flags = 6'b000001; e.imm = sx; end
            K_BNE:  begin e.alu = A_SUB; e.br = B_NE; e.flags = 6'b000001; e.imm = sx; end
            default: begin e.alu = A_ADD; e.br = B_UNT; e.illegal = 1'b1; end
        endcase
        return e;
    endfunction

    function automatic logic reads_reg(logic [31:0] w, logic [4:0] r);
        kind_e k;
        logic  uses_rs, uses_rt;
        k       = classify(w);
        uses_rs = !(k inside {K_SLL, K_SRL, K_ILL});
        uses_rt = k inside {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_SLL, K_SRL, K_ST, K_BEQ, K_BNE};
        return (uses_rs && (w[25:21] == r)) || (uses_rt && (w[20:16] == r));
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        int          sel;
        w   = $urandom;
        sel = $urandom_range(0, 15);
        w[25:21] = 5'($urandom_range(0, 3));
        w[20:16] = 5'($urandom_range(0, 3));
        if (sel <= 6) begin
            w[31:26] = 6'h00;
            w[15:11] = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: w[5:0] = 6'h20;
                1: w[5:0] = 6'h22;
                2: w[5:0] = 6'h24;
                3: w[5:0] = 6'h25;
                4: w[5:0] = 6'h2A;
                5: w[5:0] = 6'h00;
                6: w[5:0] = 6'h02;
                default: w[5:0] = 6'h3F;
            endcase
        end else begin
            case (sel)
                7, 15: w[31:26] = 6'h23;
                8:  w[31:26] = 6'h2B;
                9:  w[31:26] = 6'h08;
                10: w[31:26] = 6'h0C;
                11: w[31:26] = 6'h0D;
                12: w[31:26] = 6'h04;
                13: w[31:26] = 6'h05;
                default: w[31:26] = 6'h3F;
            endcase
        end
        return w;
    endfunction

    // One clock of stimulus: check outputs mid-cycle, advance the model, cross the edge.
    task automatic cycle(input logic v, input logic [31:0] w, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        logic intl, exp_rdy, acc;
        exp_t rec;
        bus.in_valid  = v;
        bus.in_insn   = w;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
        bus.flush     = fl;
        #1;
        intl    = (m_ld_cnt != 0) && v && reads_reg(w, m_ld_dst);
        exp_rdy = (exp_q.size() < DEPTH) && !fl && !intl;
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("out_valid", bus.out_valid, exp_q.size() != 0);
        chk("stall_count", bus.stall_count, m_stall);
        if (exp_q.size() != 0) begin
            chk("head", {bus.out_pc, bus.out_rs, bus.out_rt, bus.out_dst, bus.out_imm,
                         bus.out_alu_code, bus.out_br_code, bus.out_flags, bus.out_illegal},
                exp_q[0]);
        end else begin
            chk("idle_flags", {bus.out_flags, bus.out_illegal}, 7'h0);
        end
        acc = v && exp_rdy;
        rec = model(w, pc);
        if (intl && (m_stall != 32'hFFFF_FFFF)) m_stall++;
        if (fl) begin
            exp_q.delete();
            m_ld_cnt = 0;
        end else begin
            if (rdy && (exp_q.size() != 0)) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(rec);
            if (acc && (classify(w) == K_LD) && (w[20:16] != 5'd0)) begin
                m_ld_cnt = LUS;
                m_ld_dst = w[20:16];
            end else if (m_ld_cnt > 0) begin
                m_ld_cnt--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic busy);
        rst           = 1'b0;
        bus.in_valid  = busy;
        bus.flush     = busy;
        bus.out_ready = busy;
        bus.in_insn   = 32'h2022FFFF;
        bus.in_pc     = '0;
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        exp_q.delete();
        m_ld_cnt = 0;
        m_stall  = '0;
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_stall_count", bus.stall_count, 32'd0);
    endtask

    initial begin
        do_reset(1'b0);

        // ADDI $2,$1,-1
        cycle(1'b1, 32'h2022FFFF, 32'h100, 1'b1, 1'b0);
        chk("addi_valid", bus.out_valid, 1'b1);
        chk("addi_dst", bus.out_dst, 5'd2);
        chk("addi_imm", bus.out_imm, 32'hFFFF_FFFF);
        chk("addi_alu", bus.out_alu_code, A_ADD);
        chk("addi_flags", bus.out_flags, 6'b000110);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // LD $3,0($1) then ADD $4,$3,$3: one interlock cycle
        do_reset(1'b0);
        cycle(1'b1, 32'h8C230000, 32'h200, 1'b1, 1'b0);
        cycle(1'b1, 32'h00632020, 32'h204, 1'b1, 1'b0);
        cycle(1'b1, 32'h00632020, 32'h204, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("lu_stall_count", bus.stall_count, 32'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Backpressure on a full FIFO, including pop-while-full
        cycle(1'b1, 32'h20010001, 32'h300, 1'b0, 1'b0);
        cycle(1'b1, 32'h20020002, 32'h304, 1'b0, 1'b0);
        chk("full_valid", bus.out_valid, 1'b1);
        cycle(1'b1, 32'h20030003, 32'h308, 1'b0, 1'b0);
        cycle(1'b1, 32'h20030003, 32'h308, 1'b1, 1'b0);
        cycle(1'b1, 32'h20030003, 32'h308, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush a full FIFO with a live load window
        cycle(1'b1, 32'h20050005, 32'h400, 1'b0, 1'b0);
        cycle(1'b1, 32'h8C050000, 32'h404, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("flush_out_valid", bus.out_valid, 1'b0);
        chk("flush_in_ready", bus.in_ready, 1'b1);
        chk("flush_stall_kept", bus.stall_count, 32'd1);
        cycle(1'b1, 32'h00A53020, 32'h408, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Illegal opcode and illegal funct
        cycle(1'b1, 32'hFC012345, 32'h500, 1'b0, 1'b0);
        chk("ill_op", bus.out_illegal, 1'b1);
        chk("ill_op_flags", bus.out_flags, 6'b000000);
        cycle(1'b1, 32'h0020003F, 32'h504, 1'b1, 1'b0);
        chk("ill_fn", bus.out_illegal, 1'b1);
        chk("ill_fn_wr", {bus.out_flags[2], bus.out_flags[0]}, 2'b00);
        repeat (2) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Reset with two buffered records and an open load window
        cycle(1'b1, 32'h8C270000, 32'h600, 1'b0, 1'b0);
        cycle(1'b1, 32'h00E74020, 32'h604, 1'b0, 1'b0);
        cycle(1'b1, 32'h8C290000, 32'h608, 1'b0, 1'b0);
        chk("pre_rst_valid", bus.out_valid, 1'b1);
        do_reset(1'b1);
        cycle(1'b1, 32'h01294820, 32'h60C, 1'b1, 1'b0);

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_insn(), $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
        end
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
